// File: rtl/dds_osc_pkg.sv
// dds_osc_pkg: shared types and the quarter-wave sine table generator for
// the time-multiplexed DDS oscillator.
package dds_osc_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam real PI = 3.14159265358979323846;

  // Entry idx of a quarter-wave table with 2^(addr_w-2) entries, sampled at
  // bin centres and scaled to the largest positive out_w-bit code.
  function automatic int quarter_sine(input int idx, input int addr_w, input int out_w);
    real depth;
    real peak;
    real x;
    depth = real'(2 ** (addr_w - 2));
    peak  = real'(2 ** (out_w - 1) - 1);
    x     = peak * $sin(PI / 2.0 * (real'(idx) + 0.5) / depth);
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// dds_quarter_lut: quarter-wave sine magnitude ROM with a registered read.
// Holds only the positive first quadrant; folding and sign live in the caller.
module dds_quarter_lut
  import dds_osc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-3:0] i_addr,
  output logic [OUT_W-2:0]  o_data
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [OUT_W-2:0] w_rom [DEPTH];
  logic [OUT_W-2:0] r_data_p1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign w_rom[g] = (OUT_W-1)'(quarter_sine(g, ADDR_W, OUT_W));
  end

  // Registered table read.
  always_ff @(posedge clk) begin
    r_data_p1 <= w_rom[i_addr];
  end

  assign o_data = r_data_p1;

endmodule

// File: rtl/dds_osc.sv
// dds_osc: multi-channel time-multiplexed DDS oscillator. One channel is
// issued per cycle during a frame; all channels share one quarter-wave ROM.
// Optional mixed output built when DDS_OSC_MIX_EN is defined.
module dds_osc
  import dds_osc_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int PHASE_W = 24,
  parameter  int ADDR_W  = 8,
  parameter  int OUT_W   = 8,
  parameter  int AMP_W   = 8,
  localparam int CH_W    = $clog2(NCH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_en,
  input  logic [NCH*PHASE_W-1:0]        fcw,
  input  logic [NCH*2-1:0]              wave_sel,
  input  logic [NCH*AMP_W-1:0]          amp,
  output logic                          busy,
  output logic signed [OUT_W-1:0]       sample,
  output logic [CH_W-1:0]               sample_ch,
  output logic                          sample_valid,
  output logic signed [OUT_W+CH_W-1:0]  mix,
  output logic                          mix_valid,
  output logic                          overrun
);

  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NCH - 1);
  localparam logic signed [OUT_W-1:0] MAX_S   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_S   = {1'b1, {(OUT_W-1){1'b0}}};

  // Subtract 2^(OUT_W-1) (an MSB flip) and fold the lone most-negative code
  // onto -MAX so every waveform is symmetric.
  function automatic logic signed [OUT_W-1:0] offset_clamp(input logic [OUT_W-1:0] u);
    logic signed [OUT_W-1:0] s;
    s = $signed({~u[OUT_W-1], u[OUT_W-2:0]});
    return (s == MIN_S) ? -MAX_S : s;
  endfunction

  // (wave * amp) >>> AMP_W with floor rounding; amp is unsigned.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] w,
                                                    input logic [AMP_W-1:0] a);
    logic signed [OUT_W+AMP_W:0] wx;
    logic signed [OUT_W+AMP_W:0] ax;
    logic signed [OUT_W+AMP_W:0] prod;
    wx   = (OUT_W+AMP_W+1)'(w);
    ax   = (OUT_W+AMP_W+1)'({1'b0, a});
    prod = wx * ax;
    prod = prod >>> AMP_W;
    return prod[OUT_W-1:0];
  endfunction

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CH_W-1:0]   r_ch_ctr;
  logic [CH_W-1:0]   w_ctr_nxt;
  logic              w_issue;
  logic              w_ovr_set;
  logic              r_overrun;

  logic [PHASE_W-1:0] r_phase [NCH];

  logic [PHASE_W-1:0]      w_phase_p0;
  logic [PHASE_W-1:0]      w_fcw_p0;
  wave_e                   w_wsel_p0;
  logic [AMP_W-1:0]        w_amp_p0;
  logic [ADDR_W-1:0]       w_p_p0;
  logic [ADDR_W-3:0]       w_idx_p0;
  logic [OUT_W-1:0]        w_tri_u_p0;
  logic signed [OUT_W-1:0] w_alt_p0;

  wave_e                   r_wsel_p1;
  logic                    r_neg_p1;
  logic signed [OUT_W-1:0] r_alt_p1;
  logic [AMP_W-1:0]        r_amp_p1;
  logic [CH_W-1:0]         r_ch_p1;
  logic                    r_vld_p1;
  logic [OUT_W-2:0]        w_rom_p1;
  logic signed [OUT_W-1:0] w_mag_p1;
  logic signed [OUT_W-1:0] w_wave_p1;

  logic signed [OUT_W-1:0] r_sample_p2;
  logic [CH_W-1:0]         r_ch_p2;
  logic                    r_vld_p2;

  // Frame sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ch_ctr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch_ctr <= w_ctr_nxt;
    end
  end

  // Frame sequencer: start on sample_en, issue one channel per RUN cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ch_ctr;
    w_issue     = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_en) begin
          w_state_nxt = RUN;
          w_ctr_nxt   = '0;
        end
      end
      RUN: begin
        w_issue   = 1'b1;
        w_ovr_set = sample_en;
        if (r_ch_ctr == LAST_CH) begin
          w_state_nxt = IDLE;
          w_ctr_nxt   = '0;
        end else begin
          w_ctr_nxt = r_ch_ctr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ctr_nxt   = '0;
      end
    endcase
  end

  assign busy = (r_state == RUN);

  // Sticky overrun flag: a frame request arrived while a frame was running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;

  // ---- stage p0: issue mux, fold and ROM address (issue cycle) ----
  // Select the issued channel's phase and controls.
  always_comb begin
    w_phase_p0 = '0;
    w_fcw_p0   = '0;
    w_wsel_p0  = WAVE_SINE;
    w_amp_p0   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch_ctr == CH_W'(c)) begin
        w_phase_p0 = r_phase[c];
        w_fcw_p0   = fcw[c*PHASE_W +: PHASE_W];
        w_wsel_p0  = wave_e'(wave_sel[2*c +: 2]);
        w_amp_p0   = amp[c*AMP_W +: AMP_W];
      end
    end
  end

  // Phase accumulators advance only when their channel is issued.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        r_phase[c] <= '0;
      end else if (w_issue && (r_ch_ctr == CH_W'(c))) begin
        r_phase[c] <= w_phase_p0 + w_fcw_p0;
      end
    end
  end

  assign w_p_p0     = w_phase_p0[PHASE_W-1 -: ADDR_W];
  assign w_idx_p0   = w_p_p0[ADDR_W-2] ? ~w_p_p0[ADDR_W-3:0] : w_p_p0[ADDR_W-3:0];
  assign w_tri_u_p0 = w_phase_p0[PHASE_W-2 -: OUT_W];

  // Non-sine waveforms are computed directly from the phase.
  always_comb begin
    w_alt_p0 = '0;
    case (w_wsel_p0)
      WAVE_SQUARE: w_alt_p0 = w_phase_p0[PHASE_W-1] ? -MAX_S : MAX_S;
      WAVE_SAW:    w_alt_p0 = offset_clamp(w_phase_p0[PHASE_W-1 -: OUT_W]);
      WAVE_TRI:    w_alt_p0 = offset_clamp(w_phase_p0[PHASE_W-1] ? ~w_tri_u_p0 : w_tri_u_p0);
      default:     w_alt_p0 = '0;
    endcase
  end

  // ---- stage p1: ROM read and sign ----
  dds_quarter_lut #(
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk    (clk),
    .i_addr (w_idx_p0),
    .o_data (w_rom_p1)
  );

  // Carry waveform controls alongside the ROM read.
  always_ff @(posedge clk) begin
    r_wsel_p1 <= w_wsel_p0;
    r_neg_p1  <= w_p_p0[ADDR_W-1];
    r_alt_p1  <= w_alt_p0;
    r_amp_p1  <= w_amp_p0;
    r_ch_p1   <= r_ch_ctr;
  end

  // Valid for stage p1.
  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= w_issue;
  end

  assign w_mag_p1  = $signed({1'b0, w_rom_p1});
  assign w_wave_p1 = (r_wsel_p1 == WAVE_SINE) ? (r_neg_p1 ? -w_mag_p1 : w_mag_p1) : r_alt_p1;

  // ---- stage p2: amplitude scaling into the output register ----
  // Output register; holds the last sample between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2    <= 1'b0;
      r_sample_p2 <= '0;
      r_ch_p2     <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sample_p2 <= scale(w_wave_p1, r_amp_p1);
        r_ch_p2     <= r_ch_p1;
      end
    end
  end

  assign sample       = r_sample_p2;
  assign sample_ch    = r_ch_p2;
  assign sample_valid = r_vld_p2;

`ifdef DDS_OSC_MIX_EN
  logic signed [OUT_W+CH_W-1:0] w_sx;
  logic signed [OUT_W+CH_W-1:0] r_acc;
  logic signed [OUT_W+CH_W-1:0] r_mix;
  logic                         r_mix_vld;

  assign w_sx = (OUT_W+CH_W)'(r_sample_p2);

  // Frame accumulator, reloaded by channel 0 so frames never mix.
  always_ff @(posedge clk) begin
    if (r_vld_p2) begin
      r_acc <= (r_ch_p2 == '0) ? w_sx : r_acc + w_sx;
    end
  end

  // Publish the frame sum when the last channel's sample arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mix_vld <= 1'b0;
      r_mix     <= '0;
    end else begin
      r_mix_vld <= r_vld_p2 && (r_ch_p2 == LAST_CH);
      if (r_vld_p2 && (r_ch_p2 == LAST_CH)) begin
        r_mix <= r_acc + w_sx;
      end
    end
  end

  assign mix       = r_mix;
  assign mix_valid = r_mix_vld;
`else
  assign mix       = '0;
  assign mix_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dds_osc.sv
// tb_dds_osc: directed bench for dds_osc (NCH=4, PHASE_W=24, OUT_W=8, AMP_W=8).
module tb_dds_osc;

  localparam int NCH     = 4;
  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = 8;
  localparam int AMP_W   = 8;
  localparam int CH_W    = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         sample_en;
  logic [NCH*PHASE_W-1:0]       fcw;
  logic [NCH*2-1:0]             wave_sel;
  logic [NCH*AMP_W-1:0]         amp;
  logic                         busy;
  logic signed [OUT_W-1:0]      sample;
  logic [CH_W-1:0]              sample_ch;
  logic                         sample_valid;
  logic signed [OUT_W+CH_W-1:0] mix;
  logic                         mix_valid;
  logic                         overrun;

  int checks = 0;
  int errors = 0;

  logic signed [OUT_W-1:0]      got_s   [NCH];
  int                           got_cyc [NCH];
  int                           n_valid;
  int                           n_mix;
  int                           mix_cyc;
  int                           busy_first;
  int                           busy_last;
  logic signed [OUT_W+CH_W-1:0] got_mix;
  int                           cnt_s;
  int                           cnt_m;

  always #5 clk = ~clk;

  dds_osc #(
    .NCH(NCH), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .AMP_W(AMP_W)
  ) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .fcw(fcw),
    .wave_sel(wave_sel), .amp(amp), .busy(busy), .sample(sample),
    .sample_ch(sample_ch), .sample_valid(sample_valid), .mix(mix),
    .mix_valid(mix_valid), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [PHASE_W-1:0] f, input logic [1:0] w,
                        input logic [AMP_W-1:0] a);
    fcw[c*PHASE_W +: PHASE_W] = f;
    wave_sel[2*c +: 2]        = w;
    amp[c*AMP_W +: AMP_W]     = a;
  endtask

  // Pulse sample_en in cycle 0 and record what the frame produces over 10 cycles.
  // At cycle chg_cyc (if nonzero) amp is replaced by chg_amp.
  task automatic run_frame(input int chg_cyc, input logic [NCH*AMP_W-1:0] chg_amp);
    n_valid = 0; n_mix = 0; mix_cyc = -1; busy_first = -1; busy_last = -1; got_mix = '0;
    for (int c = 0; c < NCH; c++) begin
      got_s[c] = '0; got_cyc[c] = -1;
    end
    sample_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) sample_en = 1'b0;
      if (k == chg_cyc) amp = chg_amp;
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (sample_valid) begin
        n_valid++;
        got_s[sample_ch]   = sample;
        got_cyc[sample_ch] = k;
      end
      if (mix_valid) begin
        n_mix++;
        got_mix = mix;
        mix_cyc = k;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [NCH];
    int sum;
    e = '{e0, e1, e2, e3};
    sum = 0;
    chk({tag, " busy_first"}, busy_first, 1);
    chk({tag, " busy_last"}, busy_last, NCH);
    chk({tag, " n_valid"}, n_valid, NCH);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s ch%0d value", tag, c), got_s[c], e[c]);
      chk($sformatf("%s ch%0d cycle", tag, c), got_cyc[c], 3 + c);
      sum += e[c];
    end
`ifdef DDS_OSC_MIX_EN
    chk({tag, " n_mix"}, n_mix, 1);
    chk({tag, " mix"}, got_mix, sum);
    chk({tag, " mix_cycle"}, mix_cyc, NCH + 3);
`else
    chk({tag, " n_mix"}, n_mix, 0);
    chk({tag, " mix_tied"}, mix, sum - sum);
`endif
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; fcw = '0; wave_sel = '0; amp = '1;
    step(); step(); step();
    chk("rst busy", busy, 0);
    chk("rst sample", sample, 0);
    chk("rst sample_ch", sample_ch, 0);
    chk("rst sample_valid", sample_valid, 0);
    chk("rst mix", mix, 0);
    chk("rst mix_valid", mix_valid, 0);
    chk("rst overrun", overrun, 0);
    reset = 1'b0;
    step();

    // Sine at phase 0 on every channel: ROM[0]=2, (2*255)>>>8 = 1; phases do not move.
    run_frame(0, '0); chk_frame("sine0_f1", 1, 1, 1, 1);
    run_frame(0, '0); chk_frame("sine0_f2", 1, 1, 1, 1);

    // ch0 saw (clamped), ch1 square half-rate, ch2 sine half-rate amp 128, ch3 sine quarter-rate.
    set_ch(0, 24'h000000, 2'd2, 8'd255);
    set_ch(1, 24'h800000, 2'd1, 8'd255);
    set_ch(2, 24'h800000, 2'd0, 8'd128);
    set_ch(3, 24'h400000, 2'd0, 8'd255);
    run_frame(0, '0); chk_frame("mixw_f1", -127,  126,  1,    1);
    run_frame(0, '0); chk_frame("mixw_f2", -127, -127, -1,  126);
    run_frame(0, '0); chk_frame("mixw_f3", -127,  126,  1,   -2);
    run_frame(0, '0); chk_frame("mixw_f4", -127, -127, -1, -127);

    // sample_en held for cycles 0..2: one frame, overrun from cycle 2.
    sample_en = 1'b1;
    step();
    chk("ovr cycle1", overrun, 0);
    step();
    chk("ovr cycle2", overrun, 1);
    sample_en = 1'b0;
    cnt_s = 0;
    for (int k = 3; k <= 12; k++) begin
      step();
      if (sample_valid) cnt_s++;
    end
    chk("ovr one_frame", cnt_s, NCH);
    chk("ovr sticky", overrun, 1);

    // Reset in cycle 2 of a frame aborts it.
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sample_valid", sample_valid, 0);
    chk("abort sample", sample, 0);
    chk("abort overrun", overrun, 0);
    cnt_s = 0; cnt_m = 0;
    for (int k = 4; k <= 12; k++) begin
      step();
      if (sample_valid) cnt_s++;
      if (mix_valid) cnt_m++;
    end
    chk("abort no_sample", cnt_s, 0);
    chk("abort no_mix", cnt_m, 0);
    run_frame(0, '0); chk_frame("after_rst", -127, 126, 1, 1);

    // All square from phase 0, then ch0 triangle at half rate.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    for (int c = 0; c < NCH; c++) set_ch(c, 24'h000000, 2'd1, 8'd255);
    run_frame(0, '0); chk_frame("square_all", 126, 126, 126, 126);
    set_ch(0, 24'h800000, 2'd3, 8'd255);
    run_frame(0, '0); chk_frame("tri_f1", -127, 126, 126, 126);
    run_frame(0, '0); chk_frame("tri_f2",  126, 126, 126, 126);

    // Amplitude change in cycle 2 reaches only channels issued from then on.
    set_ch(0, 24'h000000, 2'd1, 8'd255);
    run_frame(2, '0); chk_frame("amp_midframe", 126, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_osc.md
# dds_osc

Multi-channel, time-multiplexed direct digital synthesis oscillator. It extends the single-channel 8-bit sine player to a parametrised number of channels. Each channel has its own phase accumulator, frequency control word, waveform select and amplitude. All channels share one quarter-wave sine ROM. The block sits between the note/envelope control logic and the audio output stage, and emits one signed sample per channel per frame plus an optional mixed sum.

## Interface
- NCH, 4: channel count (≥2); CH_W = $clog2(NCH)
- PHASE_W, 24: phase accumulator width
- ADDR_W, 8: full-wave table address bits; ROM depth 2^(ADDR_W-2)
- OUT_W, 8: signed sample width; MAX = 2^(OUT_W-1)-1
- AMP_W, 8: unsigned amplitude width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sample_en  in  1  frame start strobe (sample rate)
- fcw  in  NCH*PHASE_W  per-channel frequency control words, ch0 in LSBs
- wave_sel  in  NCH*2  per-channel waveform (0 sine, 1 square, 2 saw, 3 triangle)
- amp  in  NCH*AMP_W  per-channel amplitude
- busy  out  1  frame in progress
- sample  out  OUT_W  signed scaled sample
- sample_ch  out  CH_W  channel of sample
- sample_valid  out  1  sample/sample_ch valid, one-cycle pulse per channel
- mix  out  OUT_W+CH_W  signed sum of one frame's samples
- mix_valid  out  1  one-cycle pulse
- overrun  out  1  sticky: sample_en arrived while busy

## Operation
- FSM IDLE/RUN, plus channel counter ch_ctr.
  - IDLE: when sample_en=1, go to RUN with ch_ctr=0.
  - RUN: issue channel ch_ctr each cycle. After issuing NCH-1, go to IDLE.
- Issue of channel c: capture phase[c], fcw[c], wave_sel[c] and amp[c] into the pipeline. Then phase[c] <= phase[c]+fcw[c], mod 2^PHASE_W, wrapping silently. The sample uses the pre-increment phase.
- p = phase[PHASE_W-1 -: ADDR_W], quadrant = p[ADDR_W-1:ADDR_W-2].
- Sine:
  - Index = q in quadrants 0/2, ~q in quadrants 1/3.
  - Negate in quadrants 2/3.
  - ROM[i] = round(MAX*sin(pi/2*(i+0.5)/2^(ADDR_W-2))).
- Square: phase MSB 0 → +MAX, 1 → -MAX.
- Saw: top OUT_W phase bits minus 2^(OUT_W-1); -2^(OUT_W-1) clamps to -MAX.
- Triangle:
  - u = OUT_W bits below the phase MSB.
  - f = MSB ? ~u : u, then minus 2^(OUT_W-1), with the same clamp.
- Scaling: sample = (wave*amp) >>> AMP_W, arithmetic shift (floor). amp=0 gives 0.
- Mix: signed accumulation of one frame's NCH samples. The accumulator reloads on ch0's output, so frames never bleed into each other.
- sample_en while busy=1 is ignored and sets overrun. overrun clears only on reset.
- Reset mid-frame aborts the frame:
  - All phases, pipeline valids, FSM, outputs and overrun go to 0.
  - No pending sample_valid or mix_valid is emitted.

## Timing
- Reset values: busy=0, sample=0, sample_ch=0, sample_valid=0, mix=0, mix_valid=0, overrun=0, all phases 0.
- sample_en high in cycle 0 with busy=0:
  - busy is high in cycles 1..NCH.
  - Channel c is issued in cycle 1+c.
  - Its sample_valid is in cycle 3+c: 3-stage pipeline of fold/addr, ROM/sign, multiply.
- mix_valid is in cycle NCH+3.
- The earliest accepted next sample_en is cycle NCH+1. The pipeline overlaps the new frame's issue.
- sample_en and reset in the same cycle: reset wins.
- fcw, wave_sel and amp are sampled only at issue, so mid-frame changes affect only channels not yet issued.

## Configuration
- DDS_OSC_MIX_EN defined: mix accumulator built; mix/mix_valid behave as above.
- DDS_OSC_MIX_EN undefined: accumulator removed; mix tied to 0, mix_valid tied to 0. Ports are unchanged.

## Structure
- dds_osc_pkg:
  - wave_e enum (WAVE_SINE, WAVE_SQUARE, WAVE_SAW, WAVE_TRI)
  - state_e (IDLE, RUN)
  - function generating the quarter-wave ROM contents from ADDR_W/OUT_W
- Sub-module dds_quarter_lut: synchronous ROM, registered read, forms pipeline stage 2.

## Test plan
- Reset, fcw all 0, sine, amp 255, one frame → sample_valid in cycles 3..6 with ch 0..3, identical values v. In the next frame the phases are unchanged and v repeats.
- ch1 square, fcw=2^(PHASE_W-1), amp 255, three frames → ch1 samples +126, -127, +126.
- ch0 saw, fcw=0, amp 255 → -127 (clamped). ch2 sine, fcw=2^(PHASE_W-1) → consecutive frames give exact negatives.
- sample_en held high cycles 0..2 → exactly one frame, overrun=1 from cycle 2 until reset.
- reset in cycle 2 of a frame → no further sample_valid/mix_valid. The next frame reproduces the phase-0 outputs.
- All channels square, fcw 0, amp 255 → each +126, mix=504 in cycle 7. With DDS_OSC_MIX_EN undefined, mix_valid never asserts.
